issue_sequencer: RTL and testbench

ISSUE_SEQUENCER -- requirements
Module: issue_sequencer

---
 rtl/issue_sequencer_pkg.sv | 29 ++
 rtl/issue_sequencer_fifo_mem.sv | 27 ++
 rtl/issue_sequencer.sv | 149 ++++++++++++++
 tb/tb_issue_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/issue_sequencer_pkg.sv
// Shared core types: instruction names, store types and the sequencer FSM states.
package issue_sequencer_pkg;

   typedef enum logic [3:0] {
      UNKNOWN = 4'd0,
      ADD     = 4'd1,
      SUB     = 4'd2,
      AND     = 4'd3,
      OR      = 4'd4,
      XOR     = 4'd5,
      LW      = 4'd6,
      SW      = 4'd7,
      BEQ     = 4'd8,
      JAL     = 4'd9
   } instr_name_e;

   typedef enum logic [1:0] {
      XX   = 2'd0,
      BYTE = 2'd1,
      HALF = 2'd2,
      WORD = 2'd3
   } st_type_e;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } issue_seq_state_e;

endpackage

// File: rtl/issue_sequencer_fifo_mem.sv
// DEPTH x W payload storage: two write ports (distinct addresses) and one async read port.
module issue_fifo_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clock,
   input  logic                     we0,
   input  logic [$clog2(DEPTH)-1:0] waddr0,
   input  logic [W-1:0]             wdata0,
   input  logic                     we1,
   input  logic [$clog2(DEPTH)-1:0] waddr1,
   input  logic [W-1:0]             wdata1,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] r_mem [DEPTH];

   // Storage is intentionally not reset; validity lives in the sequencer's count.
   always_ff @(posedge clock) begin
      if (we0) r_mem[waddr0] <= wdata0;
      if (we1) r_mem[waddr1] <= wdata1;
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/issue_sequencer.sv
// Two-wide dispatch into a circular buffer, single in-order issue toward stations and ROB.
module issue_sequencer
   import issue_sequencer_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [1:0]                 disp_valid,
   output logic                       disp_ready,
   input  logic [XLEN-1:0]            disp_address_0,
   input  logic [XLEN-1:0]            disp_immediate_0,
   input  logic [5:0]                 disp_src_1_0,
   input  logic [5:0]                 disp_src_2_0,
   input  logic [5:0]                 disp_arn_0,
   input  logic [5:0]                 disp_rrn_0,
   input  logic                       disp_jump_0,
   input  logic                       disp_tag_0,
   input  instr_name_e                disp_instr_name_0,
   input  st_type_e                   disp_st_type_0,
   input  logic [XLEN-1:0]            disp_address_1,
   input  logic [XLEN-1:0]            disp_immediate_1,
   input  logic [5:0]                 disp_src_1_1,
   input  logic [5:0]                 disp_src_2_1,
   input  logic [5:0]                 disp_arn_1,
   input  logic [5:0]                 disp_rrn_1,
   input  logic                       disp_jump_1,
   input  logic                       disp_tag_1,
   input  instr_name_e                disp_instr_name_1,
   input  st_type_e                   disp_st_type_1,
   output logic                       issue_valid,
   output logic [XLEN-1:0]            address,
   output logic [XLEN-1:0]            immediate,
   output logic [5:0]                 src_1,
   output logic [5:0]                 src_2,
   output logic [5:0]                 arn,
   output logic [5:0]                 rrn,
   output logic                       jump,
   output logic                       tag,
   output instr_name_e                instr_name,
   output st_type_e                   st_type,
   input  logic                       station_ready,
   input  logic                       rob_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int NW  = $bits(instr_name_e);
   localparam int TW  = $bits(st_type_e);
   localparam int PLW = 2*XLEN + 4*6 + 2 + NW + TW;

   issue_seq_state_e r_state, w_state_next;
   logic [AW-1:0]    r_wptr, r_rptr, w_wptr_next, w_rptr_next;
   logic [CW-1:0]    r_count, w_count_next;
   logic             r_issue_valid;

   logic [CW-1:0]    w_nvalid, w_free, w_nacc;
   logic             w_acc, w_fire;
   logic [PLW-1:0]   w_pay0, w_pay1, w_wdata0, w_rdata;

   assign w_nvalid   = CW'(disp_valid[0]) + CW'(disp_valid[1]);
   assign w_free     = CW'(DEPTH) - r_count;
   // Space check uses registered count only, so a same-cycle fire never frees room combinationally.
   assign disp_ready = !flush && (r_state == RUN) && (w_free >= w_nvalid);
   assign w_acc      = disp_ready && (|disp_valid);
   assign w_nacc     = w_acc ? w_nvalid : '0;
   assign w_fire     = r_issue_valid && station_ready && rob_ready && !flush;

   always_comb begin
      w_state_next = r_state;
      w_wptr_next  = r_wptr;
      w_rptr_next  = r_rptr;
      w_count_next = r_count;
      if (flush) begin
         w_state_next = FLUSH;
         w_wptr_next  = '0;
         w_rptr_next  = '0;
         w_count_next = '0;
      end else if (r_state == FLUSH) begin
         w_state_next = RUN;
      end else begin
         w_wptr_next  = r_wptr + AW'(w_nacc);
         w_rptr_next  = r_rptr + AW'(w_fire);
         w_count_next = r_count + w_nacc - CW'(w_fire);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= RUN;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_count       <= '0;
         r_issue_valid <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_wptr        <= w_wptr_next;
         r_rptr        <= w_rptr_next;
         r_count       <= w_count_next;
         r_issue_valid <= (w_count_next != '0) && (w_state_next == RUN);
      end
   end

   assign w_pay0 = {disp_address_0, disp_immediate_0, disp_src_1_0, disp_src_2_0, disp_arn_0,
                    disp_rrn_0, disp_jump_0, disp_tag_0, disp_instr_name_0, disp_st_type_0};
   assign w_pay1 = {disp_address_1, disp_immediate_1, disp_src_1_1, disp_src_2_1, disp_arn_1,
                    disp_rrn_1, disp_jump_1, disp_tag_1, disp_instr_name_1, disp_st_type_1};

   // Port 0 takes the oldest valid slot at wptr; port 1 only carries slot 1 when both are valid.
   assign w_wdata0 = disp_valid[0] ? w_pay0 : w_pay1;

   issue_fifo_mem #(.DEPTH(DEPTH), .W(PLW)) u_mem (
      .clock  (clock),
      .we0    (w_acc),
      .waddr0 (r_wptr),
      .wdata0 (w_wdata0),
      .we1    (w_acc && (&disp_valid)),
      .waddr1 (r_wptr + AW'(1)),
      .wdata1 (w_pay1),
      .raddr  (r_rptr),
      .rdata  (w_rdata)
   );

   logic [XLEN-1:0] w_r_address, w_r_immediate;
   logic [5:0]      w_r_src_1, w_r_src_2, w_r_arn, w_r_rrn;
   logic            w_r_jump, w_r_tag;
   logic [NW-1:0]   w_r_name;
   logic [TW-1:0]   w_r_st;

   assign {w_r_address, w_r_immediate, w_r_src_1, w_r_src_2, w_r_arn, w_r_rrn,
           w_r_jump, w_r_tag, w_r_name, w_r_st} = w_rdata;

   assign issue_valid = r_issue_valid;
   assign count       = r_count;
   assign address     = r_issue_valid ? w_r_address   : 'z;
   assign immediate   = r_issue_valid ? w_r_immediate : 'z;
   assign src_1       = r_issue_valid ? w_r_src_1     : 'z;
   assign src_2       = r_issue_valid ? w_r_src_2     : 'z;
   assign arn         = r_issue_valid ? w_r_arn       : 'z;
   assign rrn         = r_issue_valid ? w_r_rrn       : 'z;
   assign jump        = r_issue_valid ? w_r_jump      : 1'bz;
   assign tag         = r_issue_valid ? w_r_tag       : 1'bz;
   assign instr_name  = r_issue_valid ? instr_name_e'(w_r_name) : UNKNOWN;
   assign st_type     = r_issue_valid ? st_type_e'(w_r_st)      : XX;

endmodule

// File: tb/tb_issue_sequencer.sv
// Randomized + directed bench for issue_sequencer against a queue-based reference model.
module tb_issue_sequencer;
   import issue_sequencer_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]  disp_valid = '0;
   logic        disp_ready;
   logic [31:0] disp_address_0 = '0, disp_immediate_0 = '0, disp_address_1 = '0, disp_immediate_1 = '0;
   logic [5:0]  disp_src_1_0 = '0, disp_src_2_0 = '0, disp_arn_0 = '0, disp_rrn_0 = '0;
   logic [5:0]  disp_src_1_1 = '0, disp_src_2_1 = '0, disp_arn_1 = '0, disp_rrn_1 = '0;
   logic        disp_jump_0 = 1'b0, disp_tag_0 = 1'b0, disp_jump_1 = 1'b0, disp_tag_1 = 1'b0;
   instr_name_e disp_instr_name_0 = UNKNOWN, disp_instr_name_1 = UNKNOWN;
   st_type_e    disp_st_type_0 = XX, disp_st_type_1 = XX;
   logic        issue_valid;
   logic [31:0] address, immediate;
   logic [5:0]  src_1, src_2, arn, rrn;
   logic        jump, tag;
   instr_name_e instr_name;
   st_type_e    st_type;
   logic        station_ready = 1'b0, rob_ready = 1'b0, flush = 1'b0;
   logic [2:0]  count;

   issue_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_address_0(disp_address_0), .disp_immediate_0(disp_immediate_0),
      .disp_src_1_0(disp_src_1_0), .disp_src_2_0(disp_src_2_0), .disp_arn_0(disp_arn_0),
      .disp_rrn_0(disp_rrn_0), .disp_jump_0(disp_jump_0), .disp_tag_0(disp_tag_0),
      .disp_instr_name_0(disp_instr_name_0), .disp_st_type_0(disp_st_type_0),
      .disp_address_1(disp_address_1), .disp_immediate_1(disp_immediate_1),
      .disp_src_1_1(disp_src_1_1), .disp_src_2_1(disp_src_2_1), .disp_arn_1(disp_arn_1),
      .disp_rrn_1(disp_rrn_1), .disp_jump_1(disp_jump_1), .disp_tag_1(disp_tag_1),
      .disp_instr_name_1(disp_instr_name_1), .disp_st_type_1(disp_st_type_1),
      .issue_valid(issue_valid), .address(address), .immediate(immediate),
      .src_1(src_1), .src_2(src_2), .arn(arn), .rrn(rrn), .jump(jump), .tag(tag),
      .instr_name(instr_name), .st_type(st_type),
      .station_ready(station_ready), .rob_ready(rob_ready), .flush(flush), .count(count)
   );

   typedef struct {
      logic [31:0] addr, imm;
      logic [5:0]  s1, s2, arn, rrn;
      logic        jump, tag;
      instr_name_e nm;
      st_type_e    st;
   } pay_t;

   pay_t q[$];
   bit   in_flush;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag_s, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag_s, obs, exp);
      end
   endtask

   function automatic pay_t mkpay(input logic [31:0] a, input instr_name_e nm);
      pay_t p;
      p.addr = a;
      p.imm  = $urandom;
      p.s1   = 6'($urandom);
      p.s2   = 6'($urandom);
      p.arn  = 6'($urandom);
      p.rrn  = 6'($urandom);
      p.jump = 1'($urandom);
      p.tag  = 1'($urandom);
      p.nm   = nm;
      p.st   = st_type_e'($urandom_range(0, 3));
      return p;
   endfunction

   function automatic pay_t rndpay();
      return mkpay($urandom, instr_name_e'($urandom_range(1, 9)));
   endfunction

   // One cycle: drive at negedge, check against the model, then advance the model for the edge.
   task automatic step(input logic [1:0] v, input pay_t p0, input pay_t p1,
                       input logic sr, input logic rr, input logic fl);
      bit exp_iv, exp_rdy;
      @(negedge clock);
      disp_valid = v; station_ready = sr; rob_ready = rr; flush = fl;
      disp_address_0 = p0.addr; disp_immediate_0 = p0.imm; disp_src_1_0 = p0.s1;
      disp_src_2_0 = p0.s2; disp_arn_0 = p0.arn; disp_rrn_0 = p0.rrn; disp_jump_0 = p0.jump;
      disp_tag_0 = p0.tag; disp_instr_name_0 = p0.nm; disp_st_type_0 = p0.st;
      disp_address_1 = p1.addr; disp_immediate_1 = p1.imm; disp_src_1_1 = p1.s1;
      disp_src_2_1 = p1.s2; disp_arn_1 = p1.arn; disp_rrn_1 = p1.rrn; disp_jump_1 = p1.jump;
      disp_tag_1 = p1.tag; disp_instr_name_1 = p1.nm; disp_st_type_1 = p1.st;
      #1;
      exp_iv  = (q.size() != 0) && !in_flush;
      exp_rdy = !fl && !in_flush && ((DEPTH - q.size()) >= $countones(v));
      chk("count", 64'(count), 64'(q.size()));
      chk("issue_valid", 64'(issue_valid), 64'(exp_iv));
      chk("disp_ready", 64'(disp_ready), 64'(exp_rdy));
      if (exp_iv) begin
         chk("address", 64'(address), 64'(q[0].addr));
         chk("immediate", 64'(immediate), 64'(q[0].imm));
         chk("fields", 64'({src_1, src_2, arn, rrn, jump, tag, instr_name, st_type}),
             64'({q[0].s1, q[0].s2, q[0].arn, q[0].rrn, q[0].jump, q[0].tag, q[0].nm, q[0].st}));
      end else begin
         chk("idle_name", 64'(instr_name), 64'(UNKNOWN));
         chk("idle_st", 64'(st_type), 64'(XX));
      end
      if (fl) begin
         q.delete();
         in_flush = 1'b1;
      end else if (in_flush) begin
         in_flush = 1'b0;
      end else begin
         if (exp_iv && sr && rr) void'(q.pop_front());
         if (exp_rdy && v[0]) q.push_back(p0);
         if (exp_rdy && v[1]) q.push_back(p1);
      end
   endtask

   task automatic idle(input logic sr, input logic rr, input int n);
      for (int i = 0; i < n; i++) step(2'b00, rndpay(), rndpay(), sr, rr, 1'b0);
   endtask

   initial begin
      in_flush = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_issue_valid", 64'(issue_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_name", 64'(instr_name), 64'(UNKNOWN));
      chk("rst_st", 64'(st_type), 64'(XX));
      @(negedge clock);
      reset = 1'b1;

      // Ordered pair into an empty buffer
      step(2'b11, mkpay(32'h100, ADD), mkpay(32'h104, SUB), 1'b1, 1'b1, 1'b0);
      idle(1'b1, 1'b1, 3);

      // Fill to full with ROB stalled, then a single slot must be refused
      step(2'b11, rndpay(), rndpay(), 1'b1, 1'b0, 1'b0);
      step(2'b11, rndpay(), rndpay(), 1'b1, 1'b0, 1'b0);
      step(2'b01, rndpay(), rndpay(), 1'b1, 1'b0, 1'b0);
      step(2'b10, rndpay(), rndpay(), 1'b1, 1'b0, 1'b0);
      idle(1'b1, 1'b1, 5);

      // Near-full: pair refused, single accepted
      step(2'b11, rndpay(), rndpay(), 1'b0, 1'b0, 1'b0);
      step(2'b01, rndpay(), rndpay(), 1'b0, 1'b0, 1'b0);
      step(2'b11, rndpay(), rndpay(), 1'b0, 1'b0, 1'b0);
      step(2'b01, rndpay(), rndpay(), 1'b0, 1'b0, 1'b0);
      idle(1'b0, 1'b0, 1);
      idle(1'b1, 1'b1, 5);

      // Slot 1 only
      step(2'b10, mkpay(32'hdead, ADD), mkpay(32'h200, LW), 1'b1, 1'b1, 1'b0);
      idle(1'b1, 1'b1, 2);

      // Flush at count 3 alongside a dispatch pair and ready consumers
      step(2'b11, rndpay(), rndpay(), 1'b1, 1'b0, 1'b0);
      step(2'b01, rndpay(), rndpay(), 1'b1, 1'b0, 1'b0);
      step(2'b11, rndpay(), rndpay(), 1'b1, 1'b1, 1'b1);
      step(2'b11, rndpay(), rndpay(), 1'b1, 1'b1, 1'b0);
      step(2'b11, mkpay(32'h300, XOR), mkpay(32'h304, OR), 1'b1, 1'b1, 1'b0);
      idle(1'b1, 1'b1, 3);

      // Asynchronous reset mid-cycle at count 2
      step(2'b11, rndpay(), rndpay(), 1'b1, 1'b0, 1'b0);
      idle(1'b1, 1'b0, 1);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_issue_valid", 64'(issue_valid), 64'd0);
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_name", 64'(instr_name), 64'(UNKNOWN));
      q.delete();
      in_flush = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      step(2'b11, mkpay(32'h400, BEQ), mkpay(32'h404, JAL), 1'b1, 1'b1, 1'b0);
      idle(1'b1, 1'b1, 3);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         step(2'($urandom), rndpay(), rndpay(), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
